// File: rtl/f_pcgen_pkg.sv
// Shared types and constants for the f_pcgen fetch PC generator and its BTB.
package f_pcgen_pkg;

  localparam int unsigned PC_W = 13;

  typedef logic [PC_W-1:0] pc_t;

  // Values match the branch_number convention used further down the pipeline.
  typedef enum logic [1:0] {
    PSLOT_NONE = 2'b00,
    PSLOT_1    = 2'b01,
    PSLOT_2    = 2'b10
  } pslot_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Result of one BTB lookup port.
  typedef struct packed {
    logic hit;
    logic taken;
    pc_t  target;
  } btb_rd_t;

  // 2-bit saturating counter step toward the resolved direction.
  function automatic ctr_e ctr_train(ctr_e c, logic taken);
    ctr_e n;
    n = c;
    if (taken && (c != ST)) begin
      n = ctr_e'(2'(c + 2'd1));
    end else if (!taken && (c != SNT)) begin
      n = ctr_e'(2'(c - 2'd1));
    end
    return n;
  endfunction

endpackage

// File: rtl/f_pcgen_if.sv
// Fetch-side bundle: decode-stage redirect/training in, dual-issue fetch pair and prediction out.
interface f_pcgen_if;
  import f_pcgen_pkg::*;

  logic       stall;
  logic       redirect;
  pc_t        redirect_pc;
  logic       upd_valid;
  pc_t        upd_pc;
  pc_t        upd_target;
  logic       upd_taken;
  pc_t        pc1;
  pc_t        pc2;
  logic       valid2;
  logic [1:0] pred_slot;
  pc_t        pc_predicted;

  modport master (
    output stall, redirect, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
    input  pc1, pc2, valid2, pred_slot, pc_predicted
  );

  modport slave (
    input  stall, redirect, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken,
    output pc1, pc2, valid2, pred_slot, pc_predicted
  );

endinterface

// File: rtl/f_pcgen_btb.sv
// f_btb: direct-mapped BTB with 2-bit direction counters, two lookup ports and one training port.
// Define F_BTB_BYPASS_EN to forward a same-cycle update to matching lookups.
module f_btb
  import f_pcgen_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  pc_t     look_pc1,
  input  pc_t     look_pc2,
  input  logic    upd_valid,
  input  pc_t     upd_pc,
  input  pc_t     upd_target,
  input  logic    upd_taken,
  output btb_rd_t rd1,
  output btb_rd_t rd2
);

  localparam int unsigned N_ENT = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W = PC_W - BTB_IDX_W;

  logic [N_ENT-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [N_ENT];
  pc_t              target_q [N_ENT];
  ctr_e             ctr_q    [N_ENT];

  logic [BTB_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 upd_hit;
  logic                 w_en;
  pc_t                  w_target;
  ctr_e                 w_ctr;

  // Post-update entry for the trained index; a not-taken miss leaves the table alone.
  always_comb begin
    w_idx    = upd_pc[BTB_IDX_W-1:0];
    w_tag    = upd_pc[PC_W-1:BTB_IDX_W];
    upd_hit  = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    w_en     = upd_valid && (upd_taken || upd_hit);
    w_target = upd_taken ? upd_target : target_q[w_idx];
    w_ctr    = upd_hit ? ctr_train(ctr_q[w_idx], upd_taken) : WT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (w_en) begin
      valid_q[w_idx] <= 1'b1;
      ctr_q[w_idx]   <= w_ctr;
    end
  end

  // Tag/target payload needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && w_en) begin
      tag_q[w_idx]    <= w_tag;
      target_q[w_idx] <= w_target;
    end
  end

  pc_t look_pc [2];
  assign look_pc[0] = look_pc1;
  assign look_pc[1] = look_pc2;

  for (genvar k = 0; k < 2; k++) begin : g_port
    logic [BTB_IDX_W-1:0] idx;
    logic [TAG_W-1:0]     tag;
    logic                 e_valid;
    logic [TAG_W-1:0]     e_tag;
    pc_t                  e_target;
    ctr_e                 e_ctr;
    btb_rd_t              res;

    always_comb begin
      idx      = look_pc[k][BTB_IDX_W-1:0];
      tag      = look_pc[k][PC_W-1:BTB_IDX_W];
      e_valid  = valid_q[idx];
      e_tag    = tag_q[idx];
      e_target = target_q[idx];
      e_ctr    = ctr_q[idx];
`ifdef F_BTB_BYPASS_EN
      if (w_en && (w_idx == idx)) begin
        e_valid  = 1'b1;
        e_tag    = w_tag;
        e_target = w_target;
        e_ctr    = w_ctr;
      end
`else
`endif
      res.hit    = e_valid && (e_tag == tag);
      res.taken  = res.hit && e_ctr[1];
      res.target = e_target;
    end
  end

  assign rd1 = g_port[0].res;
  assign rd2 = g_port[1].res;

endmodule

// File: rtl/f_pcgen.sv
// f_pcgen: fetch PC register, dual-issue pair formation and next-PC prediction from the BTB.
// Same-cycle BTB update forwarding is enabled with F_BTB_BYPASS_EN (see f_btb).
module f_pcgen
  import f_pcgen_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = 4,
  parameter pc_t         RESET_PC  = 13'd0
) (
  input logic       clk,
  input logic       rst,
  f_pcgen_if.slave  bus
);

  pc_t        pc_q;
  pc_t        pc_next1;
  btb_rd_t    rd1;
  btb_rd_t    rd2;
  logic [1:0] pred_slot;
  logic       valid2;
  pc_t        pc_pred;

  assign pc_next1 = pc_q + PC_W'(1);

  f_btb #(
    .BTB_IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .look_pc1   (pc_q),
    .look_pc2   (pc_next1),
    .upd_valid  (bus.upd_valid),
    .upd_pc     (bus.upd_pc),
    .upd_target (bus.upd_target),
    .upd_taken  (bus.upd_taken),
    .rd1        (rd1),
    .rd2        (rd2)
  );

  // Slot 1 prediction wins and kills slot 2; otherwise fall through two words.
  always_comb begin
    pred_slot = PSLOT_NONE;
    valid2    = 1'b1;
    pc_pred   = pc_q + PC_W'(2);
    if (rd1.taken) begin
      pred_slot = PSLOT_1;
      valid2    = 1'b0;
      pc_pred   = rd1.target;
    end else if (rd2.taken) begin
      pred_slot = PSLOT_2;
      pc_pred   = rd2.target;
    end
  end

  // A redirect overrides a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect) begin
      pc_q <= bus.redirect_pc;
    end else if (!bus.stall) begin
      pc_q <= pc_pred;
    end
  end

  assign bus.pc1          = pc_q;
  assign bus.pc2          = pc_next1;
  assign bus.valid2       = valid2;
  assign bus.pred_slot    = pred_slot;
  assign bus.pc_predicted = pc_pred;

endmodule

// File: tb/tb_f_pcgen.sv
// Self-checking bench for f_pcgen: directed scenarios plus randomized traffic against a behavioural model.
module tb_f_pcgen;
  import f_pcgen_pkg::*;

  localparam int NE  = 16;
  localparam int PCM = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f_pcgen_if bus ();

  f_pcgen #(
    .BTB_IDX_W (4),
    .RESET_PC  (13'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit v;
    int tag;
    int tgt;
    int ctr;
  } ent_t;

  ent_t btb [NE];
  int   mpc;
  int   n_checks = 0;
  int   n_errors = 0;
  int   s_pc1, s_pc2, s_v2, s_slot, s_pred;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t trained(ent_t e, int pc, int tgt, bit tk);
    ent_t r = e;
    bit hit = e.v && (e.tag == pc / NE);
    if (tk && hit) begin
      r.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
      r.tgt = tgt;
    end else if (tk) begin
      r = '{v: 1'b1, tag: pc / NE, tgt: tgt, ctr: 2};
    end else if (hit) begin
      r.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
    end
    return r;
  endfunction

  function automatic ent_t view(int pc);
    ent_t e = btb[pc % NE];
`ifdef F_BTB_BYPASS_EN
    if (bus.upd_valid && (int'(bus.upd_pc) % NE == pc % NE))
      e = trained(e, int'(bus.upd_pc), int'(bus.upd_target), bus.upd_taken);
`endif
    return e;
  endfunction

  function automatic bit pred_taken(ent_t e, int pc);
    return e.v && (e.tag == pc / NE) && (e.ctr >= 2);
  endfunction

  task automatic model_reset();
    mpc = 0;
    for (int i = 0; i < NE; i++) btb[i] = '{v: 1'b0, tag: 0, tgt: 0, ctr: 1};
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_target = '0;
    bus.upd_taken = 1'b0;
  endtask

  // Compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    int p1, p2, es, ev2, ep;
    ent_t e1, e2;
    @(negedge clk);
    p1 = mpc;
    p2 = (mpc + 1) % PCM;
    e1 = view(p1);
    e2 = view(p2);
    if (pred_taken(e1, p1)) begin
      es = 1; ev2 = 0; ep = e1.tgt;
    end else if (pred_taken(e2, p2)) begin
      es = 2; ev2 = 1; ep = e2.tgt;
    end else begin
      es = 0; ev2 = 1; ep = (mpc + 2) % PCM;
    end
    s_pc1 = int'(bus.pc1);
    s_pc2 = int'(bus.pc2);
    s_v2 = int'(bus.valid2);
    s_slot = int'(bus.pred_slot);
    s_pred = int'(bus.pc_predicted);
    check_val("pc1", s_pc1, p1);
    check_val("pc2", s_pc2, p2);
    check_val("valid2", s_v2, ev2);
    check_val("pred_slot", s_slot, es);
    check_val("pc_predicted", s_pred, ep);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (bus.upd_valid)
        btb[int'(bus.upd_pc) % NE] = trained(btb[int'(bus.upd_pc) % NE], int'(bus.upd_pc),
                                             int'(bus.upd_target), bus.upd_taken);
      if (bus.redirect) mpc = int'(bus.redirect_pc);
      else if (!bus.stall) mpc = ep;
    end
    #1;
  endtask

  task automatic train(input int pc, input int tgt, input bit tk);
    idle();
    bus.upd_valid = 1'b1;
    bus.upd_pc = 13'(pc);
    bus.upd_target = 13'(tgt);
    bus.upd_taken = tk;
    cycle();
  endtask

  task automatic jump(input int pc);
    idle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 13'(pc);
    cycle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    do_reset();

    // Sequential fetch out of reset
    cycle();
    check_val("rst_pc1", s_pc1, 0);
    check_val("rst_pc2", s_pc2, 1);
    check_val("rst_slot", s_slot, 0);
    check_val("rst_pred", s_pred, 2);
    cycle();
    check_val("seq_pc1_b", s_pc1, 2);
    cycle();
    check_val("seq_pc1_c", s_pc1, 4);
    check_val("seq_pc2_c", s_pc2, 5);

    // Allocate a taken branch, then fetch it
    train('h010, 'h100, 1'b1);
    jump('h010);
    idle();
    cycle();
    check_val("trn_pc1", s_pc1, 'h010);
    check_val("trn_slot", s_slot, 1);
    check_val("trn_valid2", s_v2, 0);
    check_val("trn_pred", s_pred, 'h100);
    cycle();
    check_val("trn_follow", s_pc1, 'h100);

    // Counter hysteresis on slot 2
    do_reset();
    train('h011, 'h200, 1'b1);
    jump('h010);
    idle();
    cycle();
    check_val("hys_slot2", s_slot, 2);
    check_val("hys_pred2", s_pred, 'h200);
    train('h011, 'h200, 1'b0);
    train('h011, 'h200, 1'b0);
    jump('h010);
    idle();
    cycle();
    check_val("hys_slot_snt", s_slot, 0);
    check_val("hys_pred_snt", s_pred, 'h012);
    train('h011, 'h200, 1'b1);
    jump('h010);
    idle();
    cycle();
    check_val("hys_slot_wnt", s_slot, 0);

    // Redirect beats stall, then stall holds
    idle();
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 13'h055;
    cycle();
    idle();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("stall_pc1", s_pc1, 'h055);
    end

    // Wrap-around at the top of the address space
    jump('h1FFF);
    idle();
    cycle();
    check_val("wrap_pc1", s_pc1, 'h1FFF);
    check_val("wrap_pc2", s_pc2, 0);
    check_val("wrap_pred", s_pred, 1);

    // Same-cycle allocate and lookup
    jump('h020);
    train('h020, 'h300, 1'b1);
    check_val("same_pc1", s_pc1, 'h020);
`ifdef F_BTB_BYPASS_EN
    check_val("same_slot", s_slot, 1);
`else
    check_val("same_slot", s_slot, 0);
`endif

    // Randomized traffic over a small address window to get plenty of hits
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.redirect = ($urandom_range(0, 5) == 0);
      bus.redirect_pc = ($urandom_range(0, 15) == 0) ? 13'($urandom) : 13'($urandom_range(0, 63));
      bus.upd_valid = ($urandom_range(0, 1) == 1);
      bus.upd_pc = ($urandom_range(0, 31) == 0) ? 13'($urandom) : 13'($urandom_range(0, 63));
      bus.upd_target = ($urandom_range(0, 1) == 1) ? 13'($urandom) : 13'($urandom_range(0, 63));
      bus.upd_taken = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/f_pcgen.md
Name: f_pcgen

Overview:
- Fetch-stage PC generator with branch target buffer (BTB) and 2-bit saturating direction counters.
- Produces the dual-issue fetch pair (pc1, pc2) each cycle, plus the predicted next PC that the decode-stage PC-resolution logic later compares against the resolved PC.
- Takes redirect and training updates back from the decode stage.
- PCs are 13-bit word addresses.

Parameters:
- BTB_IDX_W, 4, index bits; BTB holds 2**BTB_IDX_W entries.
- RESET_PC, 13'd0, fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold the fetch PC (downstream not accepting)
- redirect  in  1  decode-stage mispredict (fail_predict)
- redirect_pc  in  13  correct PC (true_pc)
- upd_valid  in  1  decode stage resolved a jump/branch this cycle
- upd_pc  in  13  PC of the resolved instruction
- upd_target  in  13  resolved jump target
- upd_taken  in  1  resolved direction (jal/jalr always 1)
- pc1  out  13  fetch PC, slot 1
- pc2  out  13  pc1+1, slot 2
- valid2  out  1  slot 2 is on the predicted path
- pred_slot  out  2  01: slot1 predicted taken; 10: slot2 predicted taken; 00: none
- pc_predicted  out  13  next fetch PC chosen by this block

Behaviour:
- Reset value and synchronicity are as stated in Ports; reset state:
  - pc_q = RESET_PC
  - all BTB valid bits = 0
  - all counters = 2'b01 (weakly not-taken)
- Reset outputs: pc1=RESET_PC, pc2=RESET_PC+1, valid2=1, pred_slot=00, pc_predicted=RESET_PC+2.
- Indexing: index = pc[BTB_IDX_W-1:0]; tag = pc[12:BTB_IDX_W].
- Each entry holds {valid, tag, target[12:0], ctr[1:0]}.
- hitN = valid & tag match for pcN. takenN = hitN & ctr[1].
- Two combinational lookup ports (pc1, pc2) and one synchronous write port.
- Prediction priority:
  - taken1: pred_slot=01, valid2=0, pc_predicted=target(pc1).
  - else taken2: pred_slot=10, valid2=1, pc_predicted=target(pc2).
  - else: pred_slot=00, valid2=1, pc_predicted=pc1+2.
- Next PC, registered in pc_q with priority: rst > redirect > stall > pc_predicted.
  - redirect takes effect even when stall=1.
- Latency: a redirect in cycle N gives pc1=redirect_pc in cycle N+1. Flushing of wrong-path instructions is done by the pipeline registers, not here.
- All PC arithmetic is mod 2**13: pc_q=8191 gives pc2=0 and fall-through pc_predicted=1.
- Training, applied at the clock edge when upd_valid=1 (upd_hit = lookup of upd_pc):
  - taken & upd_hit: ctr saturating increment (11 stays 11); target overwritten with upd_target.
  - taken & !upd_hit: allocate; valid=1, tag, target=upd_target, ctr=2'b10.
  - !taken & upd_hit: ctr saturating decrement (00 stays 00).
  - !taken & !upd_hit: no change.
- upd_valid with rst=1: reset wins.
- Same-cycle update and lookup of the same index: lookup sees the pre-update entry, unless the optional feature below is enabled.
- redirect and upd_valid are independent; both may be applied in the same cycle.

Optional Feature:
- Macro: F_BTB_BYPASS_EN.
- Defined: a write this cycle to index i is forwarded combinationally to any lookup of index i in the same cycle. The forwarded value is the post-update entry, so a freshly allocated taken branch predicts immediately.
- Undefined: reads return the stored array contents only; the update becomes visible the cycle after.

Decomposition:
- Constants go in define.vh:
  - PC width 13
  - pred_slot encodings (PSLOT_NONE=2'b00, PSLOT_1=2'b01, PSLOT_2=2'b10), matching the branch_number convention
  - counter encodings (SNT=00, WNT=01, WT=10, ST=11)
- One sub-module, f_btb: storage array, two read ports, one write port, counter update logic, and the optional bypass.
- f_pcgen keeps pc_q, the priority mux and the output formation.

Test Plan:
- Reset, no updates, 3 cycles with stall=0: pc1 = 0, 2, 4; pc2 = 1, 3, 5; pred_slot=00 throughout.
- Training: upd_valid, upd_pc=0x010, upd_target=0x100, upd_taken=1; then redirect_pc=0x010 → next cycle pc1=0x010, pred_slot=01, valid2=0, pc_predicted=0x100, then pc1=0x100.
- Hysteresis: entry at 0x011 with ctr=10, two not-taken updates → ctr=00. Fetch at 0x010 → pred_slot=00, pc_predicted=0x012. One taken update → ctr=01, still not predicted taken.
- stall=1 and redirect=1 (redirect_pc=0x055) in the same cycle → next pc1=0x055. stall alone for 3 cycles → pc1 unchanged.
- Wrap: redirect_pc=0x1FFF, no BTB hit → pc2=0x0000, pc_predicted=0x0001.
- Same-cycle allocate and lookup at 0x020 with taken: without F_BTB_BYPASS_EN → pred_slot=00; with F_BTB_BYPASS_EN → pred_slot=01.
